// File: rtl/io_port_bank.sv
`default_nettype none
// ============================================================================
// Module      : io_port_bank
// Description : Memory-mapped GPIO bank with OUT/IN registers and a
//               change-detect interrupt (STATUS W1C, MASK).
// Revision    : 1.0 - initial release
// ============================================================================
module io_port_bank #(
    parameter int          NUM_IN    = 2,
    parameter int          NUM_OUT   = 2,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata,
    input  logic                      we,
    input  logic                      re,
    output logic [31:0]               rdata,
    output logic                      rvalid,
    input  logic [NUM_IN*DATA_W-1:0]  in_ports,
    output logic [NUM_OUT*DATA_W-1:0] out_ports,
    output logic                      irq
);

    localparam logic [1:0] c_REGION_OUT = 2'b00;
    localparam logic [1:0] c_REGION_IN  = 2'b01;
    localparam logic [1:0] c_REGION_CSR = 2'b10;
    localparam logic [3:0] c_IDX_STATUS = 4'd0;
    localparam logic [3:0] c_IDX_MASK   = 4'd1;

    logic               w_hit;
    logic [1:0]         w_region;
    logic [3:0]         w_idx;
    logic               w_wr;
    logic               w_rd;
    logic               w_sel_status;
    logic               w_sel_mask;
    logic               w_armed;
    logic [NUM_IN-1:0]  w_change;
    logic [NUM_IN-1:0]  w_clr;
    logic [NUM_IN-1:0]  w_status_nxt;
    logic [31:0]        w_rd_val;
    logic               w_unused;

    logic [DATA_W-1:0]  r_out   [NUM_OUT];
    logic [DATA_W-1:0]  r_sync1 [NUM_IN];
    logic [DATA_W-1:0]  r_sync2 [NUM_IN];
    logic [DATA_W-1:0]  r_prev  [NUM_IN];
    logic [NUM_IN-1:0]  r_status;
    logic [NUM_IN-1:0]  r_mask;
    logic [1:0]         r_arm_cnt;
    logic [31:0]        r_rdata;
    logic               r_rvalid;
    logic               r_irq;

    // Word offset = addr[7:2]; upper two bits pick the region, lower four the port.
    assign w_hit        = (addr[31:8] == BASE_ADDR[31:8]);
    assign w_region     = addr[7:6];
    assign w_idx        = addr[5:2];
    assign w_wr         = we && w_hit;
    assign w_rd         = re && w_hit;
    assign w_sel_status = (w_region == c_REGION_CSR) && (w_idx == c_IDX_STATUS);
    assign w_sel_mask   = (w_region == c_REGION_CSR) && (w_idx == c_IDX_MASK);
    assign w_unused     = ^{addr[1:0], wdata};

    // The previous-sample registers hold stale zeros until the synchronizer
    // and previous stage have both been refilled after reset.
    assign w_armed      = (r_arm_cnt == 2'd3);

    assign w_clr        = (w_wr && w_sel_status) ? wdata[NUM_IN-1:0] : '0;
    assign w_status_nxt = (r_status & ~w_clr) | w_change;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_sync1[gi] <= '0;
                    r_sync2[gi] <= '0;
                    r_prev[gi]  <= '0;
                end else begin
                    r_sync1[gi] <= in_ports[gi*DATA_W +: DATA_W];
                    r_sync2[gi] <= r_sync1[gi];
                    r_prev[gi]  <= r_sync2[gi];
                end
            end
            assign w_change[gi] = w_armed && (r_sync2[gi] != r_prev[gi]);
        end

        for (genvar go = 0; go < NUM_OUT; go++) begin : g_out
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_out[go] <= '0;
                end else if (w_wr && (w_region == c_REGION_OUT) && (w_idx == 4'(go))) begin
                    r_out[go] <= wdata[DATA_W-1:0];
                end
            end
            assign out_ports[go*DATA_W +: DATA_W] = r_out[go];
        end
    endgenerate

    always_comb begin
        w_rd_val = '0;
        case (w_region)
            c_REGION_OUT: begin
                for (int i = 0; i < NUM_OUT; i++) begin
                    if (w_idx == 4'(i)) w_rd_val[DATA_W-1:0] = r_out[i];
                end
            end
            c_REGION_IN: begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (w_idx == 4'(i)) w_rd_val[DATA_W-1:0] = r_sync2[i];
                end
            end
            c_REGION_CSR: begin
                if (w_sel_status)    w_rd_val[NUM_IN-1:0] = r_status;
                else if (w_sel_mask) w_rd_val[NUM_IN-1:0] = r_mask;
            end
            default: w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_status  <= '0;
            r_mask    <= '0;
            r_arm_cnt <= '0;
            r_irq     <= 1'b0;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
        end else begin
            r_status <= w_status_nxt;
            if (w_wr && w_sel_mask) r_mask <= wdata[NUM_IN-1:0];
            if (!w_armed) r_arm_cnt <= r_arm_cnt + 2'd1;
            r_irq    <= |(r_status & r_mask);
            r_rvalid <= w_rd;
            if (w_rd) r_rdata <= w_rd_val;
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign irq    = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_io_port_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_port_bank
// Description : Scoreboard bench for io_port_bank with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_port_bank;

    localparam int          NUM_IN    = 2;
    localparam int          NUM_OUT   = 2;
    localparam int          DATA_W    = 32;
    localparam logic [31:0] BASE_ADDR = 32'h1000_0200;

    logic                      clock;
    logic                      reset;
    logic [31:0]               addr;
    logic [31:0]               wdata;
    logic                      we;
    logic                      re;
    logic [31:0]               rdata;
    logic                      rvalid;
    logic [NUM_IN*DATA_W-1:0]  in_ports;
    logic [NUM_OUT*DATA_W-1:0] out_ports;
    logic                      irq;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    io_port_bank #(
        .NUM_IN    (NUM_IN),
        .NUM_OUT   (NUM_OUT),
        .DATA_W    (DATA_W),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .addr      (addr),
        .wdata     (wdata),
        .we        (we),
        .re        (re),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .in_ports  (in_ports),
        .out_ports (out_ports),
        .irq       (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        addr  = BASE_ADDR | {24'h0, off};
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp);
        exp_q.push_back(exp);
        addr = BASE_ADDR | {24'h0, off};
        re   = 1'b1;
        tick();
        re   = 1'b0;
    endtask

    // Monitor: every rvalid beat consumes one expected read response.
    initial begin
        forever begin
            @(negedge clock);
            if (rvalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_rvalid: got rdata 0x%0h with no read outstanding", rdata);
                end else begin
                    chk("read_data", {32'h0, rdata}, {32'h0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        reset    = 1'b1;
        addr     = '0;
        wdata    = '0;
        we       = 1'b0;
        re       = 1'b0;
        in_ports = '0;
        tick(2);
        chk("reset_out_ports", out_ports, 64'h0);
        chk("reset_irq",       {63'h0, irq}, 64'h0);
        chk("reset_rvalid",    {63'h0, rvalid}, 64'h0);
        chk("reset_rdata",     {32'h0, rdata}, 64'h0);
        reset = 1'b0;
        tick(4);

        // OUT write and readback
        wr(8'h04, 32'hDEAD_BEEF);
        chk("out1_write", out_ports, 64'hDEAD_BEEF_0000_0000);
        rd(8'h04, 32'hDEAD_BEEF);
        rd(8'h00, 32'h0);
        rd(8'h07, 32'hDEAD_BEEF);

        // Decode miss: no response and rdata holds its last value
        addr = BASE_ADDR ^ 32'h0000_0100;
        re   = 1'b1;
        tick();
        re   = 1'b0;
        chk("miss_rvalid", {63'h0, rvalid}, 64'h0);
        chk("miss_rdata_hold", {32'h0, rdata}, {32'h0, 32'hDEAD_BEEF});

        // Decoded but unmapped / out of range reads return 0
        rd(8'h90, 32'h0);
        rd(8'h08, 32'h0);
        rd(8'h48, 32'h0);

        // Writes that must not land
        addr  = BASE_ADDR ^ 32'h0000_0100;
        wdata = 32'hFFFF_FFFF;
        we    = 1'b1;
        tick();
        we    = 1'b0;
        wr(8'h40, 32'hAAAA_AAAA);
        wr(8'h08, 32'h5555_5555);
        chk("ignored_writes", out_ports, 64'hDEAD_BEEF_0000_0000);
        rd(8'h40, 32'h0);

        // Change on port 1: STATUS sets on the third edge after first sample
        in_ports[63:32] = 32'h5;
        tick(2);
        rd(8'h80, 32'h0);
        rd(8'h80, 32'h2);
        rd(8'h44, 32'h5);

        // MASK -> irq one cycle later
        wr(8'h84, 32'h2);
        chk("irq_before", {63'h0, irq}, 64'h0);
        tick();
        chk("irq_set", {63'h0, irq}, 64'h1);
        rd(8'h84, 32'h2);

        // W1C clears STATUS, irq drops a cycle later
        wr(8'h80, 32'h2);
        tick();
        chk("irq_clear", {63'h0, irq}, 64'h0);
        rd(8'h80, 32'h0);

        // Set wins over a same-cycle clear
        in_ports[31:0] = 32'h1;
        tick(2);
        wr(8'h80, 32'h1);
        rd(8'h80, 32'h1);
        wr(8'h80, 32'h2);
        rd(8'h80, 32'h1);
        wr(8'h80, 32'h1);
        rd(8'h80, 32'h0);

        // Simultaneous write and read returns the old value
        wr(8'h00, 32'h11);
        exp_q.push_back(32'h11);
        addr  = BASE_ADDR;
        wdata = 32'h22;
        we    = 1'b1;
        re    = 1'b1;
        tick();
        we    = 1'b0;
        re    = 1'b0;
        chk("wr_rd_out0", {32'h0, out_ports[31:0]}, {32'h0, 32'h22});
        rd(8'h00, 32'h22);

        // Reset in the middle of operation
        wr(8'h00, 32'h1234);
        wr(8'h84, 32'h3);
        in_ports[31:0] = 32'h2;
        tick(3);
        chk("irq_pre_reset_low", {63'h0, irq}, 64'h0);
        tick();
        chk("irq_pre_reset_high", {63'h0, irq}, 64'h1);
        in_ports[63:32] = 32'h77;
        reset = 1'b1;
        addr  = BASE_ADDR | 32'h04;
        wdata = 32'hFFFF;
        we    = 1'b1;
        re    = 1'b1;
        tick();
        reset = 1'b0;
        we    = 1'b0;
        re    = 1'b0;
        chk("rst_out_ports", out_ports, 64'h0);
        chk("rst_irq",       {63'h0, irq}, 64'h0);
        chk("rst_rvalid",    {63'h0, rvalid}, 64'h0);
        chk("rst_rdata",     {32'h0, rdata}, 64'h0);
        tick(6);
        rd(8'h80, 32'h0);
        rd(8'h84, 32'h0);
        rd(8'h40, 32'h2);
        rd(8'h44, 32'h77);
        rd(8'h04, 32'h0);
        chk("post_rst_irq", {63'h0, irq}, 64'h0);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d reads outstanding, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_port_bank.md
IO_PORT_BANK -- requirements
Module: io_port_bank

Interface
REQ-001 Parameter: NUM_IN, 2, number of input ports; legal range 1..8.
REQ-002 Parameter: NUM_OUT, 2, number of output ports; legal range 1..8.
REQ-003 Parameter: DATA_W, 32, port data width; legal range 8..32.
REQ-004 Parameter: BASE_ADDR, 32'h0000_0000, bank base byte address; bits [7:0] SHALL be zero.
REQ-005 Port: clock  in  1  single clock; all state updates on its rising edge.
REQ-006 Port: reset  in  1  synchronous, active-high reset.
REQ-007 Port: addr  in  32  byte address from the CPU data-memory path.
REQ-008 Port: wdata  in  32  write data; only bits [DATA_W-1:0] are used.
REQ-009 Port: we  in  1  write strobe, one access per cycle.
REQ-010 Port: re  in  1  read strobe.
REQ-011 Port: rdata  out  32  registered read data, zero-extended from DATA_W.
REQ-012 Port: rvalid  out  1  high for exactly one cycle, in the cycle after an accepted read.
REQ-013 Port: in_ports  in  NUM_IN*DATA_W  asynchronous inputs; port i occupies slice [i*DATA_W +: DATA_W].
REQ-014 Port: out_ports  out  NUM_OUT*DATA_W  registered outputs; port i occupies slice [i*DATA_W +: DATA_W].
REQ-015 Port: irq  out  1  registered change interrupt.

Function
REQ-016 Access SHALL be decoded when addr[31:8] == BASE_ADDR[31:8]; addr[1:0] SHALL be ignored.
REQ-017 Offset map: 0x00+4*i OUT[i] (R/W); 0x40+4*i IN[i] (RO); 0x80 STATUS (W1C, NUM_IN bits); 0x84 MASK (R/W, NUM_IN bits).
REQ-018 Each in_ports slice SHALL pass through a 2-flop synchronizer; IN[i] SHALL return the second-stage value.
REQ-019 A previous-sample register per port SHALL hold the synchronized value from the prior cycle; STATUS[i] SHALL be set in the cycle after synchronized IN[i] differs from its previous sample.
REQ-020 Input-to-STATUS latency: a stable change on in_ports SHALL set STATUS 3 clock edges after it is first sampled.
REQ-021 A write to STATUS SHALL clear each bit written as 1; bits written as 0 SHALL be unchanged.
REQ-022 Set and clear of the same STATUS bit in the same cycle: set SHALL win and the bit SHALL stay 1.
REQ-023 irq SHALL be registered as the OR of (STATUS & MASK); it SHALL follow STATUS/MASK changes by one cycle.
REQ-024 A write to OUT[i] SHALL update out_ports slice i at the next edge; OUT[i] readback SHALL return the stored value.
REQ-025 Read data SHALL be captured at the edge where re is high and SHALL be presented on rdata, with rvalid=1, for one cycle; rdata SHALL hold its value until the next read.
REQ-026 Reads of unmapped offsets, of i >= NUM_OUT/NUM_IN, or with the decode miss SHALL return 0 with rvalid=1 if decoded, rvalid=0 if not decoded.
REQ-027 Writes to RO, unmapped or out-of-range offsets SHALL have no effect.
REQ-028 When we and re are both high, the write SHALL take effect and the read SHALL return the pre-write value.
REQ-029 Reads SHALL have no side effects; STATUS SHALL be cleared only by W1C.

Reset
REQ-030 While reset=1 at an edge: OUT, STATUS, MASK, synchronizers, previous samples, rdata, rvalid and irq SHALL all go to 0.
REQ-031 Reset SHALL override a simultaneous we/re; no write SHALL land and rvalid SHALL be 0 in the following cycle.
REQ-032 The first edge after reset deassertion SHALL NOT set STATUS from the zeroed previous samples; change detection SHALL be armed only after the synchronizer has been reloaded for 2 cycles.

Verification
REQ-033 Write 0xDEADBEEF to 0x04 (DATA_W=32) -> out_ports[63:32]=0xDEADBEEF next cycle; read 0x04 -> rdata=0xDEADBEEF, rvalid=1 one cycle later.
REQ-034 Toggle in_ports slice 1 from 0 to 0x5 -> STATUS=0b10 after 3 edges; MASK=0b10 -> irq=1 one cycle later; W1C 0b10 -> STATUS=0, irq=0 next cycle.
REQ-035 W1C STATUS bit 0 in the same cycle a new change on port 0 sets it -> STATUS[0] remains 1.
REQ-036 Read 0x90, 0x08 with NUM_OUT=2, and addr outside BASE_ADDR -> rdata=0 with rvalid=1, 0 with rvalid=1, and rvalid=0 respectively.
REQ-037 Assert reset mid-operation with OUT[0]=0x1234, MASK=0b11, irq=1 -> all outputs 0 next edge; hold in_ports non-zero across deassertion -> STATUS stays 0.
REQ-038 Simultaneous we=1/re=1 to 0x00 with old value 0x11, wdata 0x22 -> rdata=0x11, OUT[0]=0x22.
